// File: rtl/box_overlay.sv
// box_overlay: draws up to N_BOX rectangle outlines over an RGB video stream, 2-clock latency.
// Define BOX_OVERLAY_ALPHA_EN to blend box colour 50% with the pixel instead of replacing it.
module box_overlay #(
  parameter  int N_BOX  = 4,
  parameter  int H_ACT  = 1280,
  parameter  int V_ACT  = 720,
  parameter  int BORDER = 2,
  localparam int XW     = $clog2(H_ACT),
  localparam int YW     = $clog2(V_ACT),
  localparam int IW     = $clog2(N_BOX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_idx,
  input  logic          cfg_en,
  input  logic [XW-1:0] cfg_sx,
  input  logic [XW-1:0] cfg_ex,
  input  logic [YW-1:0] cfg_sy,
  input  logic [YW-1:0] cfg_ey,
  input  logic [23:0]   cfg_color,
  input  logic          i_vsync,
  input  logic          i_hsync,
  input  logic          i_de,
  input  logic [7:0]    i_r,
  input  logic [7:0]    i_g,
  input  logic [7:0]    i_b,
  output logic          o_vsync,
  output logic          o_hsync,
  output logic          o_de,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b
);

  typedef struct packed {
    logic          en;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [23:0]   color;
  } box_t;

  localparam logic [XW:0]   BX    = (XW+1)'(BORDER);
  localparam logic [YW:0]   BY    = (YW+1)'(BORDER);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACT - 1);

  box_t          shadow [N_BOX];
  box_t          live   [N_BOX];

  logic          vs_prev, de_prev, ready_q;
  logic          vs_edge;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic          s1_vs, s1_hs, s1_de;
  logic [23:0]   s1_rgb;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  logic          hit_any;
  logic [23:0]   hit_color;
  logic [23:0]   mix_rgb;

  assign vs_edge = i_vsync & ~vs_prev;
  // Writes stall on the commit cycle so the shadow table is stable while it is copied.
  assign cfg_ready = ready_q & ~vs_edge & ~rst;

  // One extra bit of headroom so sx+BORDER / x+BORDER never wrap at the right/bottom edge.
  function automatic logic box_hit(input box_t b, input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [XW:0] xe, sx, ex;
    logic [YW:0] ye, sy, ey;
    logic        outer, inner;
    xe    = {1'b0, x};
    sx    = {1'b0, b.sx};
    ex    = {1'b0, b.ex};
    ye    = {1'b0, y};
    sy    = {1'b0, b.sy};
    ey    = {1'b0, b.ey};
    outer = b.en && (xe >= sx) && (xe <= ex) && (ye >= sy) && (ye <= ey);
    inner = (xe >= sx + BX) && (xe + BX <= ex) && (ye >= sy + BY) && (ye + BY <= ey);
    return outer && !inner;
  endfunction

`ifdef BOX_OVERLAY_ALPHA_EN
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
      ready_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      // NOTE: the box tables are reset explicitly; an unreset slot could draw garbage after power-up.
      for (int k = 0; k < N_BOX; k++) begin
        shadow[k] <= '0;
        live[k]   <= '0;
      end
    end else begin
      vs_prev <= i_vsync;
      de_prev <= i_de;
      ready_q <= 1'b1;

      if (!i_de)
        x_q <= '0;
      else if (x_q != X_MAX)
        x_q <= x_q + 1'b1;

      if (vs_edge)
        y_q <= '0;
      else if (!i_de && de_prev && (y_q != Y_MAX))
        y_q <= y_q + 1'b1;

      if (cfg_valid && cfg_ready && (int'(cfg_idx) < N_BOX))
        shadow[cfg_idx] <= '{en: cfg_en, sx: cfg_sx, sy: cfg_sy,
                             ex: cfg_ex, ey: cfg_ey, color: cfg_color};

      if (vs_edge)
        for (int k = 0; k < N_BOX; k++)
          live[k] <= shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vs  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_de  <= 1'b0;
      s1_rgb <= '0;
      s1_x   <= '0;
      s1_y   <= '0;
    end else begin
      s1_vs  <= i_vsync;
      s1_hs  <= i_hsync;
      s1_de  <= i_de;
      s1_rgb <= {i_r, i_g, i_b};
      s1_x   <= x_q;
      s1_y   <= y_q;
    end
  end

  always_comb begin
    // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
    hit_any   = 1'b0;
    hit_color = '0;
    // Later slots overwrite earlier ones: the highest-index hit wins.
    for (int k = 0; k < N_BOX; k++) begin
      if (box_hit(live[k], s1_x, s1_y)) begin
        hit_any   = 1'b1;
        hit_color = live[k].color;
      end
    end
  end

  always_comb begin
    mix_rgb = s1_rgb;
    if (s1_de && hit_any) begin
`ifdef BOX_OVERLAY_ALPHA_EN
      mix_rgb = {avg8(hit_color[23:16], s1_rgb[23:16]),
                 avg8(hit_color[15:8],  s1_rgb[15:8]),
                 avg8(hit_color[7:0],   s1_rgb[7:0])};
`else
      mix_rgb = hit_color;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_de    <= 1'b0;
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
    end else begin
      o_vsync <= s1_vs;
      o_hsync <= s1_hs;
      o_de    <= s1_de;
      o_r     <= mix_rgb[23:16];
      o_g     <= mix_rgb[15:8];
      o_b     <= mix_rgb[7:0];
    end
  end

endmodule
